// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the irq_ctrl interrupt controller.
// Register map, FSM state encoding and STATUS register bit positions.
package irq_ctrl_pkg;

   localparam logic [1:0] IRQ_ENABLE_A  = 2'd0;
   localparam logic [1:0] IRQ_PENDING_A = 2'd1;
   localparam logic [1:0] IRQ_MODE_A    = 2'd2;
   localparam logic [1:0] IRQ_STATUS_A  = 2'd3;

   localparam int STAT_IRQ_B  = 8;
   localparam int STAT_SERV_B = 9;

   typedef enum logic [1:0] {
      IRQ_IDLE,
      IRQ_REQ,
      IRQ_SERV
   } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the
// index of the lowest set bit.
module irq_prio_enc #(
   parameter int N  = 8,
   parameter int IW = 5
) (
   input  logic [N-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      valid = |req;
      idx   = '0;
      // Scan downwards so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller with a four-register bus slave and a
// request/ack/eoi servicing FSM. Define IRQ_CTRL_SYNC_EN to add a 2-flop input synchroniser.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int SRC_NUM = 8,
   parameter int ID_W    = 5
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [SRC_NUM-1:0] irq_src,
   input  logic [1:0]         bus_addr,
   input  logic               bus_we,
   input  logic [31:0]        bus_wd,
   output logic [31:0]        bus_rd,
   output logic               irq,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   input  logic               irq_eoi
);

   logic [SRC_NUM-1:0] src_s;
   logic [SRC_NUM-1:0] src_q;
   logic [SRC_NUM-1:0] enable;
   logic [SRC_NUM-1:0] mode;
   logic [SRC_NUM-1:0] pending;
   logic [SRC_NUM-1:0] pending_nxt;
   logic [SRC_NUM-1:0] edge_hit;
   logic [SRC_NUM-1:0] w1c;
   logic [SRC_NUM-1:0] ack_clr;
   logic [SRC_NUM-1:0] eligible;
   logic               win_valid;
   logic [ID_W-1:0]    win_idx;
   irq_state_e         state;
   irq_state_e         state_nxt;
   logic               unused_wd;

`ifdef IRQ_CTRL_SYNC_EN
   logic [SRC_NUM-1:0] sync1;
   logic [SRC_NUM-1:0] sync2;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= irq_src;
         sync2 <= sync1;
      end
   end

   assign src_s = sync2;
`else
   assign src_s = irq_src;
`endif

   assign edge_hit  = src_s & ~src_q;
   assign w1c       = (bus_we && bus_addr == IRQ_PENDING_A) ? bus_wd[SRC_NUM-1:0] : '0;
   assign eligible  = pending & enable;
   assign unused_wd = ^bus_wd;

   always_comb begin
      ack_clr = '0;
      if (state == IRQ_REQ && irq_ack) begin
         for (int i = 0; i < SRC_NUM; i++) ack_clr[i] = (irq_id == ID_W'(i));
      end
   end

   // Edge bits hold until cleared, with a simultaneous new edge winning;
   // level bits simply mirror the sampled line.
   assign pending_nxt = (mode & ((pending & ~w1c & ~ack_clr) | edge_hit))
                      | (~mode & src_s);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         enable  <= '0;
         mode    <= '0;
         pending <= '0;
         src_q   <= '0;
      end else begin
         src_q   <= src_s;
         pending <= pending_nxt;
         if (bus_we && bus_addr == IRQ_ENABLE_A) enable <= bus_wd[SRC_NUM-1:0];
         if (bus_we && bus_addr == IRQ_MODE_A)   mode   <= bus_wd[SRC_NUM-1:0];
      end
   end

   irq_prio_enc #(
      .N  (SRC_NUM),
      .IW (ID_W)
   ) u_prio (
      .req   (eligible),
      .valid (win_valid),
      .idx   (win_idx)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IRQ_IDLE: if (win_valid) state_nxt = IRQ_REQ;
         IRQ_REQ:  if (irq_ack)   state_nxt = IRQ_SERV;
         IRQ_SERV: if (irq_eoi)   state_nxt = IRQ_IDLE;
         default:                 state_nxt = IRQ_IDLE;
      endcase
   end

   // irq_id is captured only on leaving IDLE, so it stays put through REQ.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IRQ_IDLE;
         irq    <= 1'b0;
         irq_id <= '0;
      end else begin
         state <= state_nxt;
         irq   <= (state_nxt == IRQ_REQ);
         if (state == IRQ_IDLE && win_valid) irq_id <= win_idx;
      end
   end

   always_comb begin
      bus_rd = '0;
      case (bus_addr)
         IRQ_ENABLE_A:  bus_rd[SRC_NUM-1:0] = enable;
         IRQ_PENDING_A: bus_rd[SRC_NUM-1:0] = pending;
         IRQ_MODE_A:    bus_rd[SRC_NUM-1:0] = mode;
         IRQ_STATUS_A: begin
            bus_rd[ID_W-1:0]    = irq_id;
            bus_rd[STAT_IRQ_B]  = irq;
            bus_rd[STAT_SERV_B] = (state == IRQ_SERV);
         end
         default: bus_rd = '0;
      endcase
   end

endmodule
